xor_arbiter: RTL and testbench

Shares one registered W-bit XOR unit among N_REQ requesters. Each requester offers an operand pair with a valid/ready handshake. The arbiter grants one requester per cycle, captures c = a ^ b into a one-entry output register, and presents the result tagged with the winner's index. It sits between the operand sources and the single XOR datapath, and it is the only path to that datapath.

---
 rtl/xor_arbiter.sv | 141 ++++++++++++++
 tb/tb_xor_arbiter.sv | 296 +++++++++++++++++++++++++++++
 2 files changed

// File: rtl/xor_arbiter.sv
// Shares one registered XOR unit among N_REQ valid/ready requesters.
// Define XOR_ARB_RR_EN for round-robin arbitration; otherwise the lowest index wins.
module xor_arbiter #(
    parameter int unsigned N_REQ = 4,
    parameter int unsigned W     = 8,
    localparam int unsigned IDW  = $clog2(N_REQ)
) (
    input  logic               clk,
    input  logic               rst_n,
    input  logic [N_REQ-1:0]   req_valid,
    input  logic [N_REQ*W-1:0] req_a,
    input  logic [N_REQ*W-1:0] req_b,
    output logic [N_REQ-1:0]   req_ready,
    output logic               rsp_valid,
    input  logic               rsp_ready,
    output logic [W-1:0]       rsp_c,
    output logic [IDW-1:0]     rsp_id
);

    typedef enum logic {
        EMPTY = 1'b0,
        FULL  = 1'b1
    } state_t;

    state_t         state;
    state_t         state_nxt;
    logic [W-1:0]   c_nxt;
    logic [IDW-1:0] id_nxt;

    logic           gnt_any;
    logic [IDW-1:0] gnt_id;
    logic           accept_ok;
    logic           accept;
    logic [W-1:0]   op_a;
    logic [W-1:0]   op_b;

`ifdef XOR_ARB_RR_EN
    logic [IDW-1:0] last_id;
    logic [IDW-1:0] last_nxt;
    logic [IDW-1:0] idx;

    // Rotating search starting just after the previous winner.
    always_comb begin : grant_search
        gnt_any = 1'b0;
        gnt_id  = '0;
        idx     = '0;
        for (int unsigned k = 0; k < N_REQ; k++) begin
            idx = IDW'((32'(last_id) + 32'd1 + k) % N_REQ);
            if (!gnt_any && req_valid[idx]) begin
                gnt_any = 1'b1;
                gnt_id  = idx;
            end
        end
    end
`else
    // Fixed priority: lowest set index wins.
    always_comb begin : grant_search
        gnt_any = 1'b0;
        gnt_id  = '0;
        for (int unsigned k = 0; k < N_REQ; k++) begin
            if (!gnt_any && req_valid[IDW'(k)]) begin
                gnt_any = 1'b1;
                gnt_id  = IDW'(k);
            end
        end
    end
`endif

    // A new pair may enter when the result slot is free or being popped; reset blocks grants.
    assign accept_ok = (state == EMPTY) || rsp_ready;
    assign accept    = rst_n && accept_ok && gnt_any;

    always_comb begin : ready_decode
        req_ready = '0;
        if (accept) begin
            req_ready[gnt_id] = 1'b1;
        end
    end

    // Only the winner's lane is ever loaded, so idle lanes cannot leak X.
    always_comb begin : operand_mux
        op_a = '0;
        op_b = '0;
        for (int unsigned i = 0; i < N_REQ; i++) begin
            if (gnt_id == IDW'(i)) begin
                op_a = req_a[i*W +: W];
                op_b = req_b[i*W +: W];
            end
        end
    end

    always_comb begin : next_state
        state_nxt = state;
        c_nxt     = rsp_c;
        id_nxt    = rsp_id;
`ifdef XOR_ARB_RR_EN
        last_nxt  = last_id;
`endif
        case (state)
            EMPTY: begin
                if (accept) begin
                    state_nxt = FULL;
                end
            end
            FULL: begin
                if (rsp_ready && !accept) begin
                    state_nxt = EMPTY;
                end
            end
            default: state_nxt = EMPTY;
        endcase
        if (accept) begin
            c_nxt    = op_a ^ op_b;
            id_nxt   = gnt_id;
`ifdef XOR_ARB_RR_EN
            last_nxt = gnt_id;
`endif
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin : out_regs
        if (!rst_n) begin
            state   <= EMPTY;
            rsp_c   <= '0;
            rsp_id  <= '0;
`ifdef XOR_ARB_RR_EN
            last_id <= IDW'(N_REQ - 1);
`endif
        end else begin
            state   <= state_nxt;
            rsp_c   <= c_nxt;
            rsp_id  <= id_nxt;
`ifdef XOR_ARB_RR_EN
            last_id <= last_nxt;
`endif
        end
    end

    assign rsp_valid = (state == FULL);

endmodule

// File: tb/tb_xor_arbiter.sv
// Self-checking bench for xor_arbiter: directed cases plus randomized traffic
// checked every cycle against a queue-free behavioural model.
module tb_xor_arbiter;
    localparam int unsigned N   = 4;
    localparam int unsigned W   = 8;
    localparam int unsigned IDW = 2;

    logic             clk = 1'b0;
    logic             rst_n;
    logic [N-1:0]     req_valid;
    logic [N*W-1:0]   req_a;
    logic [N*W-1:0]   req_b;
    logic [N-1:0]     req_ready;
    logic             rsp_valid;
    logic             rsp_ready;
    logic [W-1:0]     rsp_c;
    logic [IDW-1:0]   rsp_id;

    int total = 0;
    int bad   = 0;

    always #5 clk = ~clk;

    xor_arbiter #(.N_REQ(N), .W(W)) dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .req_valid (req_valid),
        .req_a     (req_a),
        .req_b     (req_b),
        .req_ready (req_ready),
        .rsp_valid (rsp_valid),
        .rsp_ready (rsp_ready),
        .rsp_c     (rsp_c),
        .rsp_id    (rsp_id)
    );

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", name, act, exp, $time);
        end
    endtask

    // First valid index scanning upward from last+1, wrapping; -1 if none.
    function automatic int pick(input logic [N-1:0] v, input int last);
        for (int k = 1; k <= int'(N); k++) begin
            int idx;
            idx = (last + k) % int'(N);
            if (v[idx]) return idx;
        end
        return -1;
    endfunction

    // Behavioural model: result slot contents plus the last winner.
    logic         m_valid;
    logic [W-1:0] m_c;
    int           m_id;
    int           m_last;

    initial begin : model_check
        logic [N-1:0] exp_rdy;
        logic         acc;
        int           g;
        logic         n_valid;
        logic [W-1:0] n_c;
        int           n_id;
        int           n_last;
        m_valid = 1'b0; m_c = '0; m_id = 0; m_last = N - 1;
        forever begin
            @(negedge clk);
            exp_rdy = '0;
            acc     = 1'b0;
            g       = -1;
            if (!rst_n) begin
                m_valid = 1'b0; m_c = '0; m_id = 0; m_last = N - 1;
            end else begin
                g   = pick(req_valid, m_last);
                acc = (!m_valid || rsp_ready) && (g >= 0);
                if (acc) exp_rdy[g] = 1'b1;
            end
            chk("req_ready", 32'(req_ready), 32'(exp_rdy));
            chk("rsp_valid", 32'(rsp_valid), 32'(m_valid));
            chk("rsp_c",     32'(rsp_c),     32'(m_c));
            chk("rsp_id",    32'(rsp_id),    32'(m_id));
            n_valid = m_valid; n_c = m_c; n_id = m_id; n_last = m_last;
            if (acc) begin
                n_valid = 1'b1;
                n_c     = req_a[g*W +: W] ^ req_b[g*W +: W];
                n_id    = g;
`ifdef XOR_ARB_RR_EN
                n_last  = g;
`endif
            end else if (m_valid && rsp_ready) begin
                n_valid = 1'b0;
            end
            @(posedge clk);
            if (!rst_n) begin
                m_valid = 1'b0; m_c = '0; m_id = 0; m_last = N - 1;
            end else begin
                m_valid = n_valid; m_c = n_c; m_id = n_id; m_last = n_last;
            end
        end
    end

    initial begin : watchdog
        #500000;
        $display("FAIL watchdog: still running at %0t, expected finish", $time);
        $fatal(1);
    end

    task automatic cyc();
        @(posedge clk);
        #1;
    endtask

    task automatic set_lane(input int i, input logic [W-1:0] a, input logic [W-1:0] b);
        req_a[i*W +: W] = a;
        req_b[i*W +: W] = b;
    endtask

    task automatic do_reset();
        rst_n     = 1'b0;
        req_valid = '0;
        repeat (2) @(posedge clk);
        #1;
        rst_n = 1'b1;
    endtask

`ifdef XOR_ARB_RR_EN
    int exp_ids [5] = '{0, 1, 2, 3, 0};
`else
    int exp_ids [5] = '{0, 0, 0, 0, 0};
`endif

    initial begin : main
        logic [N-1:0] granted;
        rst_n     = 1'b0;
        req_valid = '1;
        req_a     = 32'hDEADBEEF;
        req_b     = 32'h12345678;
        rsp_ready = 1'b0;

        // Reset with every requester asking
        @(negedge clk);
        @(negedge clk);
        chk("rst_ready", 32'(req_ready), 32'h0);
        chk("rst_valid", 32'(rsp_valid), 32'h0);
        chk("rst_c",     32'(rsp_c),     32'h0);
        chk("rst_id",    32'(rsp_id),    32'h0);

        // Single request, accepted on the first edge after reset release
        @(posedge clk);
        #1;
        rst_n     = 1'b1;
        req_valid = 4'b0100;
        req_a     = 'x;
        req_b     = 'x;
        set_lane(2, 8'hA5, 8'h0F);
        rsp_ready = 1'b1;
        @(negedge clk);
        chk("single_ready", 32'(req_ready), 32'h4);
        cyc();
        req_valid = '0;
        @(negedge clk);
        chk("single_valid", 32'(rsp_valid), 32'h1);
        chk("single_c",     32'(rsp_c),     32'hAA);
        chk("single_id",    32'(rsp_id),    32'h2);
        cyc();
        @(negedge clk);
        chk("single_empty", 32'(rsp_valid), 32'h0);

        // All four requesters valid continuously
        do_reset();
        for (int i = 0; i < int'(N); i++) set_lane(i, W'(8'h11 * i), 8'h80);
        req_valid = '1;
        rsp_ready = 1'b1;
        for (int i = 0; i < 5; i++) begin
            cyc();
            @(negedge clk);
            chk("rr_id", 32'(rsp_id), 32'(exp_ids[i]));
        end
        cyc();
        req_valid = '0;
        cyc();

        // Backpressure with requesters 1 and 3 waiting
        do_reset();
        req_a = 'x;
        req_b = 'x;
        set_lane(0, 8'h12, 8'h34);
        req_valid = 4'b0001;
        rsp_ready = 1'b0;
        cyc();
        req_valid = 4'b1010;
        set_lane(0, 'x, 'x);
        set_lane(1, 8'h55, 8'hF0);
        set_lane(3, 8'h0F, 8'hFF);
        for (int i = 0; i < 5; i++) begin
            @(negedge clk);
            chk("bp_ready", 32'(req_ready), 32'h0);
            chk("bp_c",     32'(rsp_c),     32'h26);
            chk("bp_valid", 32'(rsp_valid), 32'h1);
            cyc();
        end
        rsp_ready = 1'b1;
        @(negedge clk);
        chk("bp_release_ready", 32'(req_ready), 32'h2);
        cyc();
        req_valid = 4'b1000;
        @(negedge clk);
        chk("bp_push_valid", 32'(rsp_valid), 32'h1);
        chk("bp_push_c",     32'(rsp_c),     32'hA5);
        chk("bp_push_id",    32'(rsp_id),    32'h1);
        cyc();
        req_valid = '0;
        @(negedge clk);
        chk("bp_next_c",  32'(rsp_c),  32'hF0);
        chk("bp_next_id", 32'(rsp_id), 32'h3);
        cyc();

        // Requester 0 streams, then stops; output drains one cycle later
        set_lane(0, 8'h01, 8'h10);
        req_valid = 4'b0001;
        repeat (3) cyc();
        req_valid = '0;
        @(negedge clk);
        chk("drain_last", 32'(rsp_valid), 32'h1);
        chk("drain_c",    32'(rsp_c),     32'h11);
        cyc();
        @(negedge clk);
        chk("drain_empty", 32'(rsp_valid), 32'h0);

        // Reset while holding a result
        cyc();
        set_lane(2, 8'h3C, 8'h00);
        req_valid = 4'b0100;
        rsp_ready = 1'b0;
        cyc();
        req_valid = 4'b1001;
        set_lane(2, 'x, 'x);
        set_lane(0, 8'hAA, 8'h0F);
        set_lane(3, 8'h01, 8'h02);
        @(negedge clk);
        chk("mr_held_c", 32'(rsp_c), 32'h3C);
        @(posedge clk);
        #2;
        rst_n = 1'b0;
        #1;
        chk("mr_async_valid", 32'(rsp_valid), 32'h0);
        chk("mr_async_c",     32'(rsp_c),     32'h0);
        cyc();
        rst_n     = 1'b1;
        rsp_ready = 1'b1;
        @(negedge clk);
        chk("mr_first_ready", 32'(req_ready), 32'h1);
        cyc();
        req_valid = 4'b1000;
        @(negedge clk);
        chk("mr_first_id", 32'(rsp_id), 32'h0);
        chk("mr_first_c",  32'(rsp_c),  32'hA5);
        cyc();
        req_valid = '0;
        @(negedge clk);
        chk("mr_second_id", 32'(rsp_id), 32'h3);
        chk("mr_second_c",  32'(rsp_c),  32'h03);
        cyc();

        // Randomized traffic obeying the hold-until-accepted rule
        granted = '0;
        for (int n = 0; n < 2000; n++) begin
            for (int i = 0; i < int'(N); i++) begin
                if (!req_valid[i] || granted[i]) begin
                    if ($urandom_range(0, 99) < 60) begin
                        req_valid[i] = 1'b1;
                        set_lane(i, W'($urandom), W'($urandom));
                    end else begin
                        req_valid[i] = 1'b0;
                        set_lane(i, 'x, 'x);
                    end
                end
            end
            rsp_ready = ($urandom_range(0, 99) < 70);
            @(negedge clk);
            granted = req_ready;
            cyc();
        end
        req_valid = '0;
        rsp_ready = 1'b1;
        repeat (3) cyc();

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
